// File: rtl/gray_bin_arb_if.sv
// gray_bin_arb_if
//   Handshake bundle between Gray-coded requesters, the shared converter and
//   the downstream consumer.
//   req_valid/req_ready/req_data : per-requester Gray word channel
//                                  (requester k at req_data[k*DATA +: DATA])
//   out_valid/out_ready          : registered output channel handshake
//   out_data/out_id              : binary word and index of its source requester
//   master : requesters plus consumer (drives requests, accepts output)
//   slave  : the arbiter/converter
interface gray_bin_arb_if #(
  parameter int DATA = 4,
  parameter int REQ  = 4
);
  localparam int ID = $clog2(REQ);

  logic [REQ-1:0]      req_valid;
  logic [REQ-1:0]      req_ready;
  logic [REQ*DATA-1:0] req_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA-1:0]     out_data;
  logic [ID-1:0]       out_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/gray_bin_arb.sv
// gray_bin_arb
//   Round-robin arbiter in front of a single Gray-to-binary converter. One
//   requester is granted per cycle; its converted word lands in a one-entry
//   registered output stage tagged with the requester index.
//   clk    : clock, rising edge
//   reset_ : asynchronous active-low reset
//   flush  : synchronous clear of output stage and round-robin pointer
//   bus    : gray_bin_arb_if slave modport (request and output channels)
module gray_bin_arb #(
  parameter int DATA = 4,
  parameter int REQ  = 4
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            flush,
  gray_bin_arb_if.slave   bus
);
  localparam int ID = $clog2(REQ);

  logic [ID-1:0]   ptr;
  logic            out_valid_q;
  logic [DATA-1:0] out_data_q;
  logic [ID-1:0]   out_id_q;

  logic            load;
  logic            gnt_vld;
  logic [ID-1:0]   gnt_idx;
  logic [ID-1:0]   cand;
  logic            xfer;
  logic [DATA-1:0] gnt_word;
  logic [DATA-1:0] bin_word;
  logic [ID-1:0]   ptr_nxt;

  assign load = !out_valid_q || bus.out_ready;

  // First valid requester at or after ptr, wrapping modulo REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < REQ; i++) begin
      cand = ID'((int'(ptr) + i) % REQ);
      if (!gnt_vld && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // reset_ gates the grant so req_ready reads 0 while the block is held in reset.
  assign xfer = gnt_vld && load && !flush && reset_;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_word = bus.req_data[int'(gnt_idx)*DATA +: DATA];

  // Binary bit i is the XOR of Gray bits [DATA-1:i], built as a running XOR from the MSB.
  always_comb begin
    bin_word = '0;
    bin_word[DATA-1] = gnt_word[DATA-1];
    for (int i = DATA-2; i >= 0; i--) begin
      bin_word[i] = bin_word[i+1] ^ gnt_word[i];
    end
  end

  assign ptr_nxt = (gnt_idx == ID'(REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr         <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr         <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bin_word;
      out_id_q    <= gnt_idx;
      ptr         <= ptr_nxt;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
endmodule
